// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its
// consumers (the Controller reuses the length decoder and LEN constants).
package fetch_pkg;

   typedef enum logic [3:0] {
      BOOT,
      VEC_LO,
      VEC_HI,
      VEC_LD,
      OP,
      B0,
      B1,
      B2,
      HOLD
   } fetch_state_t;

   typedef logic [1:0] len_t;

   localparam logic [15:0] RESET_VEC_DEFAULT = 16'hFFFC;

   localparam len_t LEN1 = 2'd1;
   localparam len_t LEN2 = 2'd2;
   localparam len_t LEN3 = 2'd3;

endpackage

// File: rtl/instr_fetch_if.sv
// Program-memory read port plus instruction handoff and PC redirect, as seen
// between the fetch stage (master) and its memory/Controller (slave).
interface instr_fetch_if;
   import fetch_pkg::*;

   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic [15:0] instr;
   logic [7:0]  instr_op2;
   len_t        instr_len;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        pc_load;
   logic [15:0] pc_load_addr;

   modport master (
      output mem_addr, mem_rd, instr, instr_op2, instr_len, instr_pc, instr_valid,
      input  mem_rdata, instr_ready, pc_load, pc_load_addr
   );

   modport slave (
      input  mem_addr, mem_rd, instr, instr_op2, instr_len, instr_pc, instr_valid,
      output mem_rdata, instr_ready, pc_load, pc_load_addr
   );

endinterface

// File: rtl/opcode_len_decode.sv
// 6502 instruction length from the opcode byte alone (1, 2 or 3 bytes).
module opcode_len_decode
   import fetch_pkg::*;
(
   input  logic [7:0] opcode,
   output len_t       len
);

   always_comb begin
      if (opcode[3:2] == 2'b11 || opcode == 8'h20 || opcode[4:0] == 5'b11001) begin
         len = LEN3;
      end else if (opcode[3:0] == 4'h8 || opcode[3:0] == 4'hA ||
                   opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) begin
         len = LEN1;
      end else begin
         len = LEN2;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: loads the reset vector, then fetches and assembles one
// instruction at a time from a 1-cycle synchronous-read program memory.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_VEC = RESET_VEC_DEFAULT
)(
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master bus
);

   fetch_state_t state_reg;
   logic [15:0]  pc_reg;
   logic [7:0]   opcode_reg;
   logic [7:0]   operand_lo_reg;
   logic [7:0]   op2_reg;
   len_t         len_reg;
   logic [15:0]  instr_pc_reg;
   logic         valid_reg;

   len_t         dec_len;
   logic         redirect;
   logic         mem_rd_next;
   logic [15:0]  mem_addr_next;

   opcode_len_decode u_len (
      .opcode (bus.mem_rdata),
      .len    (dec_len)
   );

   assign redirect = bus.pc_load &&
                     (state_reg inside {OP, B0, B1, B2, HOLD});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= BOOT;
         pc_reg         <= 16'h0000;
         opcode_reg     <= 8'h00;
         operand_lo_reg <= 8'h00;
         op2_reg        <= 8'h00;
         len_reg        <= 2'd0;
         instr_pc_reg   <= 16'h0000;
         valid_reg      <= 1'b0;
      end else if (redirect) begin
         // Anything in flight is dropped; the read issued this cycle is never captured.
         pc_reg    <= bus.pc_load_addr;
         state_reg <= OP;
         valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            BOOT:   state_reg <= VEC_LO;
            VEC_LO: state_reg <= VEC_HI;
            VEC_HI: begin
               pc_reg[7:0] <= bus.mem_rdata;
               state_reg   <= VEC_LD;
            end
            VEC_LD: begin
               pc_reg[15:8] <= bus.mem_rdata;
               state_reg    <= OP;
            end
            OP: begin
               instr_pc_reg <= pc_reg;
               pc_reg       <= pc_reg + 16'd1;
               state_reg    <= B0;
            end
            B0: begin
               opcode_reg     <= bus.mem_rdata;
               len_reg        <= dec_len;
               operand_lo_reg <= 8'h00;
               op2_reg        <= 8'h00;
               if (dec_len != LEN1) begin
                  pc_reg    <= pc_reg + 16'd1;
                  state_reg <= B1;
               end else begin
                  state_reg <= HOLD;
                  valid_reg <= 1'b1;
               end
            end
            B1: begin
               operand_lo_reg <= bus.mem_rdata;
               if (len_reg == LEN3) begin
                  pc_reg    <= pc_reg + 16'd1;
                  state_reg <= B2;
               end else begin
                  state_reg <= HOLD;
                  valid_reg <= 1'b1;
               end
            end
            B2: begin
               op2_reg   <= bus.mem_rdata;
               state_reg <= HOLD;
               valid_reg <= 1'b1;
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  state_reg <= OP;
                  valid_reg <= 1'b0;
               end
            end
            default: state_reg <= BOOT;
         endcase
      end
   end

   // B0 always reads the next byte: the length is unknown until the opcode
   // arrives, and an unused read has no side effects.
   always_comb begin
      mem_rd_next   = 1'b0;
      mem_addr_next = 16'h0000;
      case (state_reg)
         VEC_LO: begin
            mem_rd_next   = 1'b1;
            mem_addr_next = RESET_VEC;
         end
         VEC_HI: begin
            mem_rd_next   = 1'b1;
            mem_addr_next = RESET_VEC + 16'd1;
         end
         OP, B0: begin
            mem_rd_next   = 1'b1;
            mem_addr_next = pc_reg;
         end
         B1: begin
            if (len_reg == LEN3) begin
               mem_rd_next   = 1'b1;
               mem_addr_next = pc_reg;
            end
         end
         default: begin
            mem_rd_next   = 1'b0;
            mem_addr_next = 16'h0000;
         end
      endcase
   end

   assign bus.mem_rd      = mem_rd_next;
   assign bus.mem_addr    = mem_addr_next;
   assign bus.instr       = {opcode_reg, operand_lo_reg};
   assign bus.instr_op2   = op2_reg;
   assign bus.instr_len   = len_reg;
   assign bus.instr_pc    = instr_pc_reg;
   assign bus.instr_valid = valid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a program-level model.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_VEC(16'hFFFC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [0:65535];

   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Program-level model: next instruction address and edges elapsed since
   // the fetch of that instruction began (negative while the vector loads).
   logic [15:0] mpc;
   int          cnt;
   int          edge_n;

   function automatic int ref_len(input logic [7:0] op);
      casez (op)
         8'b????11??, 8'h20, 8'b???11001:             return 3;
         8'h00, 8'h40, 8'h60, 8'b????1000, 8'b????1010: return 1;
         default:                                      return 2;
      endcase
   endfunction

   function automatic logic exp_valid();
      return (cnt >= 0) && (cnt >= ref_len(mem[mpc]) + 1);
   endfunction

   initial begin
      cnt = -4;
      mpc = 16'h0000;
      edge_n = 0;
      forever begin
         @(posedge clk);
         if (!reset) begin
            cnt = -4;
            mpc = {mem[16'hFFFD], mem[16'hFFFC]};
            edge_n = 0;
         end else begin
            edge_n++;
            if (cnt >= 0 && bus.pc_load) begin
               mpc = bus.pc_load_addr;
               cnt = 0;
            end else if (exp_valid() && bus.instr_ready) begin
               mpc = mpc + 16'(ref_len(mem[mpc]));
               cnt = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   initial begin
      logic        ev;
      logic [15:0] a1, a2;
      int          l;
      forever begin
         @(negedge clk);
         if (reset) begin
            ev = exp_valid();
            chk("valid", 32'(bus.instr_valid), 32'(ev));
            if (ev) begin
               l  = ref_len(mem[mpc]);
               a1 = mpc + 16'd1;
               a2 = mpc + 16'd2;
               chk("instr", 32'(bus.instr), 32'({mem[mpc], (l > 1) ? mem[a1] : 8'h00}));
               chk("op2", 32'(bus.instr_op2), 32'((l == 3) ? mem[a2] : 8'h00));
               chk("len", 32'(bus.instr_len), 32'(l));
               chk("pc", 32'(bus.instr_pc), 32'(mpc));
               chk("hold_rd", 32'(bus.mem_rd), 32'd0);
            end
            case (cnt)
               -4, -1: chk("idle_rd", 32'(bus.mem_rd), 32'd0);
               -3: chk("veclo_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'h1FFFC);
               -2: chk("vechi_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'h1FFFD);
               0:  chk("op_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'({1'b1, mpc}));
               default: ;
            endcase
         end
      end
   end

   task automatic to_neg(input int e);
      int g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (edge_n < e && g < 1000);
      chk("reach_edge", 32'(edge_n >= e), 32'd1);
   endtask

   task automatic hold_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic chk_instr(input string name, input logic [15:0] ins, input logic [7:0] op2,
                            input logic [1:0] len, input logic [15:0] pc);
      chk({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
      chk({name, "_instr"}, 32'(bus.instr), 32'(ins));
      chk({name, "_op2"}, 32'(bus.instr_op2), 32'(op2));
      chk({name, "_len"}, 32'(bus.instr_len), 32'(len));
      chk({name, "_pc"}, 32'(bus.instr_pc), 32'(pc));
   endtask

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.instr_ready  = 1'b0;
      bus.pc_load      = 1'b0;
      bus.pc_load_addr = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      // Reset values while held in reset
      #7;
      chk("rst_instr", 32'(bus.instr), 32'h0);
      chk("rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_rd", 32'({bus.mem_rd, bus.mem_addr}), 32'h0);
      chk("rst_len", 32'(bus.instr_len), 32'h0);

      // Reset vector fetch
      hold_reset();
      mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'h8000] = 8'hEA;
      bus.instr_ready = 1'b1;
      release_reset();
      to_neg(5);
      chk("t1_early", 32'(bus.instr_valid), 32'd0);
      to_neg(6);
      chk_instr("t1", 16'hEA00, 8'h00, 2'd1, 16'h8000);
      $display("vector fetch: instr=%h pc=%h", bus.instr, bus.instr_pc);

      // Mixed lengths with ready tied high
      hold_reset();
      mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
      mem[16'h8000] = 8'hA5; mem[16'h8001] = 8'h01; mem[16'h8002] = 8'hAD;
      mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12; mem[16'h8005] = 8'hE8;
      release_reset();
      to_neg(7);
      chk_instr("t2a", 16'hA501, 8'h00, 2'd2, 16'h8000);
      $display("mixed #1: instr=%h len=%0d pc=%h", bus.instr, bus.instr_len, bus.instr_pc);
      to_neg(11);
      chk("t2_gap1", 32'(bus.instr_valid), 32'd0);
      to_neg(12);
      chk_instr("t2b", 16'hAD34, 8'h12, 2'd3, 16'h8002);
      $display("mixed #2: instr=%h op2=%h len=%0d pc=%h", bus.instr, bus.instr_op2, bus.instr_len, bus.instr_pc);
      to_neg(14);
      chk("t2_gap2", 32'(bus.instr_valid), 32'd0);
      to_neg(15);
      chk_instr("t2c", 16'hE800, 8'h00, 2'd1, 16'h8005);
      $display("mixed #3: instr=%h len=%0d pc=%h", bus.instr, bus.instr_len, bus.instr_pc);

      // Backpressure
      hold_reset();
      mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
      mem[16'h8000] = 8'hA5; mem[16'h8001] = 8'h01; mem[16'h8002] = 8'hAD;
      bus.instr_ready = 1'b0;
      release_reset();
      to_neg(7);
      for (int i = 0; i < 5; i++) begin
         chk_instr("t3_hold", 16'hA501, 8'h00, 2'd2, 16'h8000);
         chk("t3_no_rd", 32'(bus.mem_rd), 32'd0);
         @(negedge clk);
      end
      bus.instr_ready = 1'b1;
      to_neg(13);
      chk("t3_next_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'h18002);
      $display("backpressure: next fetch addr=%h", bus.mem_addr);

      // Redirect during B1 of a 3-byte instruction
      hold_reset();
      mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
      mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
      mem[16'h9000] = 8'hEA;
      release_reset();
      to_neg(6);
      bus.pc_load = 1'b1; bus.pc_load_addr = 16'h9000;
      to_neg(7);
      bus.pc_load = 1'b0;
      chk("t4_valid", 32'(bus.instr_valid), 32'd0);
      chk("t4_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'h19000);
      to_neg(8);
      chk("t4_gap", 32'(bus.instr_valid), 32'd0);
      to_neg(9);
      chk_instr("t4", 16'hEA00, 8'h00, 2'd1, 16'h9000);
      $display("redirect in B1: instr=%h pc=%h", bus.instr, bus.instr_pc);

      // Redirect and ready together in HOLD
      hold_reset();
      mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
      mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
      mem[16'h9000] = 8'hEA;
      bus.instr_ready = 1'b0;
      release_reset();
      to_neg(8);
      chk_instr("t4b_held", 16'hAD34, 8'h12, 2'd3, 16'h8000);
      bus.pc_load = 1'b1; bus.pc_load_addr = 16'h9000; bus.instr_ready = 1'b1;
      to_neg(9);
      bus.pc_load = 1'b0;
      chk("t4b_valid", 32'(bus.instr_valid), 32'd0);
      chk("t4b_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'h19000);
      to_neg(11);
      chk_instr("t4b", 16'hEA00, 8'h00, 2'd1, 16'h9000);
      $display("redirect in HOLD: instr=%h pc=%h", bus.instr, bus.instr_pc);

      // PC wrap, then asynchronous reset during B0
      hold_reset();
      mem[16'hFFFC] = 8'hFE; mem[16'hFFFD] = 8'hFF;
      mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'h55; mem[16'h0000] = 8'hEA;
      release_reset();
      to_neg(7);
      chk_instr("t5", 16'hA955, 8'h00, 2'd2, 16'hFFFE);
      to_neg(8);
      chk("t5_wrap_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'h10000);
      $display("wrap: instr=%h next addr=%h", 16'hA955, bus.mem_addr);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t6_instr", 32'(bus.instr), 32'h0);
      chk("t6_op2", 32'(bus.instr_op2), 32'h0);
      chk("t6_len", 32'(bus.instr_len), 32'h0);
      chk("t6_pc", 32'(bus.instr_pc), 32'h0);
      chk("t6_valid", 32'(bus.instr_valid), 32'h0);
      chk("t6_rd", 32'({bus.mem_rd, bus.mem_addr}), 32'h0);
      $display("mid-fetch reset: instr=%h valid=%0b rd=%0b", bus.instr, bus.instr_valid, bus.mem_rd);
      release_reset();
      to_neg(1);
      chk("t6_vec_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'h1FFFC);
      to_neg(7);
      chk_instr("t6_refetch", 16'hA955, 8'h00, 2'd2, 16'hFFFE);

      // Randomized traffic against the model
      for (int seg = 0; seg < 6; seg++) begin
         hold_reset();
         for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
         release_reset();
         for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #2;
            bus.instr_ready  = ($urandom_range(0, 3) != 0);
            bus.pc_load      = ($urandom_range(0, 15) == 0);
            bus.pc_load_addr = 16'($urandom);
         end
         bus.pc_load = 1'b0;
         $display("random segment %0d: vector=%h checks=%0d", seg, {mem[16'hFFFD], mem[16'hFFFC]}, checks);
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the `Controller`. Reads the 6502 reset vector and then fetches instruction bytes from a synchronous-read program memory. Decodes each opcode's length (1–3 bytes) and assembles the 16-bit `{opcode, operand_lo}` word the Controller consumes on its `inputs` port, plus the high operand byte. Hands each instruction over with a valid/ready handshake and accepts PC redirects (jumps and taken branches) from the Controller.

## Interface
- `RESET_VEC`, default 16'hFFFC, address of the reset vector low byte; the high byte is at `RESET_VEC+1`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_addr`  out  16  program memory read address.
- `mem_rd`  out  1  read strobe; `mem_rdata` is valid on the cycle after `mem_rd`=1.
- `mem_rdata`  in  8  read data.
- `instr`  out  16  `{opcode, operand_lo}`; connects to the Controller's `inputs`.
- `instr_op2`  out  8  operand high byte; 00 unless length is 3.
- `instr_len`  out  2  instruction length, 1–3.
- `instr_pc`  out  16  address of the opcode byte.
- `instr_valid`  out  1  instruction held and stable.
- `instr_ready`  in  1  Controller accepts the instruction.
- `pc_load`  in  1  redirect request.
- `pc_load_addr`  in  16  redirect target.

## Operation
- **State machine states:** BOOT, VEC_LO, VEC_HI, VEC_LD, OP, B0, B1, B2, HOLD.
- **`mem_rd`/`mem_addr`:** Moore outputs decoded from the state and the PC. In any state that issues no read, `mem_rd`=0 and `mem_addr`=0000.
- **Transitions:**
  - BOOT → VEC_LO.
  - VEC_LO: read `RESET_VEC` → VEC_HI.
  - VEC_HI: capture pc[7:0]; read `RESET_VEC+1` → VEC_LD.
  - VEC_LD: capture pc[15:8] → OP.
  - OP: read pc; `instr_pc`<=pc; pc<=pc+1 → B0.
  - B0: capture opcode and `instr_len`; clear operand bytes to 00. If len>1, read pc and pc++ → B1; otherwise → HOLD.
  - B1: capture operand_lo. If len=3, read pc and pc++ → B2; otherwise → HOLD.
  - B2: capture `instr_op2` → HOLD.
  - HOLD: `instr_valid`=1. On `instr_ready`=1 → OP.
- **Length rule** (applied to the opcode byte):
  - 3 if opcode[3:2]=11, opcode=20, or opcode[4:0]=11001.
  - Otherwise 1 if opcode[3:0] is 8 or A, or opcode is 00, 40 or 60.
  - Otherwise 2.
- **PC arithmetic:** 16-bit, wraps FFFF→0000 with no flag.
- **Redirect (`pc_load`):**
  - In states OP through HOLD: pc<=`pc_load_addr`, any partial or held instruction is discarded, next state is OP, and `instr_valid` is 0 on the following cycle.
  - Ignored in BOOT and VEC_* states.
  - `pc_load` has priority over `instr_ready`. If both are high in HOLD, the held instruction counts as consumed and the fetch restarts at `pc_load_addr`.
  - A read issued in the redirect cycle is abandoned; its returned data is not captured.
- **Reset (asserted, including mid-fetch):**
  - State → BOOT; pc=0000.
  - `instr`=0000, `instr_op2`=00, `instr_len`=0, `instr_pc`=0000, `instr_valid`=0.
  - `mem_rd`=0, `mem_addr`=0000.
- `instr*` fields may change during B0–B2; they are meaningful only while `instr_valid`=1.

## Timing
- Memory latency is 1 cycle; fetching proceeds at 1 byte per cycle.
- Latency from the OP cycle to `instr_valid` high: len+1 cycles (2, 3 or 4).
- Minimum spacing between instructions with `instr_ready` tied high: len+2 cycles.
- After reset is released, the first edge moves BOOT→VEC_LO. `instr_valid` first rises after edge 6 (len 1), edge 7 (len 2) or edge 8 (len 3).
- `instr_valid` stays high with stable fields until the accepting edge.
- A read issued in the OP cycle or in a B-state cycle returns on the next edge.

## Structure
- **Shared package `fetch_pkg`:**
  - state enumeration typedef;
  - `RESET_VEC_DEFAULT`;
  - 2-bit length typedef;
  - length constants `LEN1`, `LEN2`, `LEN3`.
- **Sub-module `opcode_len_decode`:** combinational, 8-bit opcode in, 2-bit length out. Reused by the Controller for PC-relative branch math.

## Test plan
- **Reset vector fetch:** memory FFFC=00, FFFD=80 and 8000=EA (NOP), `instr_ready`=1 → first `instr_valid` with `instr`=EA00, `instr_len`=1, `instr_pc`=8000, after edge 6.
- **Mixed lengths:** 8000: A5 01 AD 34 12 E8 → three instructions, in order:
  - `instr`=A501, len 2, pc 8000;
  - `instr`=AD34, `instr_op2`=12, len 3, pc 8002;
  - `instr`=E800, len 1, pc 8005;
  - spacing of 4, 5 and 3 cycles respectively.
- **Backpressure:** `instr_ready`=0 for 5 cycles with A501 held → `instr_valid` and all fields stay constant; no `mem_rd` asserted; the next fetch reads 8002 after `instr_ready` is raised.
- **Redirect:** `pc_load`=1 with `pc_load_addr`=9000 during B1 of a 3-byte instruction → no valid for that instruction; next `mem_addr`=9000; next `instr_pc`=9000. Repeat with `pc_load` and `instr_ready` both high in HOLD → same result.
- **Wrap:** vector FFFE, memory FFFE=A9, FFFF=55 → `instr`=A955, `instr_pc`=FFFE; the next opcode is fetched from 0000.
- **Mid-fetch reset:** drive `reset` low during B0 → all outputs go to their reset values without waiting for a clock edge; the vector fetch restarts on release.
